// File: rtl/tick_scheduler_if.sv
// Configuration and grant bundle shared between the tick scheduler
// and the consumer that owns the shared resource.
interface tick_scheduler_if #(
    parameter int PW = 8
);
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [PW-1:0] cfg_period;
    logic          done;
    logic [3:0]    grant;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic [3:0]    pending;
    logic [3:0]    overrun;

    modport master (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_period,
        input  done,
        output grant,
        output grant_valid,
        output grant_id,
        output pending,
        output overrun
    );

    modport slave (
        output cfg_we,
        output cfg_ch,
        output cfg_period,
        output done,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  pending,
        input  overrun
    );
endinterface

// File: rtl/tick_scheduler.sv
// Prescaled base tick driving four periodic channels that share one
// resource through a round-robin IDLE/GRANT arbiter.
module tick_scheduler #(
    parameter int DIV = 25000000,
    parameter int CW  = 25,
    parameter int PW  = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    output logic             base_tick,
    tick_scheduler_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] TC  = CW'(DIV - 1);
    localparam logic [PW-1:0] ONE = PW'(1);

    state_t        state, state_n;
    logic [CW-1:0] pcnt;
    logic [1:0]    gid, gid_n;
    logic [1:0]    last_grant, last_n;
    logic [1:0]    pick, idx;
    logic          found;
    logic          gv;
    logic [3:0]    take, expire, granted;
    logic [3:0]    pend_q, ovr_q;
    logic [PW-1:0] period [4];
    logic [PW-1:0] ccnt [4];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pcnt      <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= enable && (pcnt == TC);
            if (enable)
                pcnt <= (pcnt == TC) ? '0 : pcnt + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            expire[i]  = base_tick && (period[i] != '0) &&
                         (ccnt[i] == period[i] - ONE);
            granted[i] = (state == GRANT) && (gid == 2'(i));
        end
    end

    // A config write beats a same-cycle expiry; a new expiry beats the
    // arbiter's pending clear.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                period[i] <= '0;
                ccnt[i]   <= '0;
            end
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.cfg_we && (bus.cfg_ch == 2'(i))) begin
                    period[i] <= bus.cfg_period;
                    ccnt[i]   <= '0;
                    pend_q[i] <= 1'b0;
                    ovr_q[i]  <= 1'b0;
                end else begin
                    if (base_tick && (period[i] != '0))
                        ccnt[i] <= expire[i] ? '0 : ccnt[i] + ONE;
                    pend_q[i] <= expire[i] | (pend_q[i] & ~take[i]);
                    if (expire[i] && (pend_q[i] || granted[i]))
                        ovr_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            gid        <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_n;
            gid        <= gid_n;
            last_grant <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        gid_n   = gid;
        last_n  = last_grant;
        found   = 1'b0;
        pick    = 2'd0;
        idx     = 2'd0;
        take    = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n    = GRANT;
                    gid_n      = pick;
                    take[pick] = 1'b1;
                end
            end
            GRANT: begin
                if (bus.done) begin
                    state_n = IDLE;
                    last_n  = gid;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign gv              = (state == GRANT);
    assign bus.grant_valid = gv;
    assign bus.grant_id    = gv ? gid : 2'd0;
    assign bus.grant       = gv ? (4'b0001 << gid) : 4'b0000;
    assign bus.pending     = pend_q;
    assign bus.overrun     = ovr_q;
endmodule
